ddr3_byte_bridge: RTL and testbench

//  Responder for the byte-wide ddr3_* request port driven by the slot/memory subsystem.

---
 rtl/ddr3_byte_bridge_pkg.sv | 25 ++
 rtl/ddr3_line_cache.sv | 44 ++++
 rtl/ddr3_byte_bridge.sv | 165 ++++++++++++++++
 tb/tb_ddr3_byte_bridge.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ddr3_byte_bridge_pkg.sv
// Shared types and widths for the byte-wide DDR3 request bridge and its line cache.
package ddr3_byte_bridge_pkg;

  localparam int unsigned DDR3_LINE_BYTES = 8;
  localparam int unsigned REQ_ADDR_W      = 28;
  localparam int unsigned LANE_W          = 3;
  localparam int unsigned TAG_W           = REQ_ADDR_W - LANE_W;
  localparam int unsigned LINE_W          = DDR3_LINE_BYTES * 8;
  localparam int unsigned DDRAM_ADDR_W    = 29;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DRAIN} ddr3_bridge_state_t;

  typedef struct packed {
    logic [DDRAM_ADDR_W-1:0]    addr;
    logic [LINE_W-1:0]          din;
    logic [DDR3_LINE_BYTES-1:0] be;
  } ddram_req_t;

  // Byte lane n of a 64-bit line lives in bits [8n+7:8n].
  function automatic logic [7:0] lane_byte(input logic [LINE_W-1:0] line,
                                           input logic [LANE_W-1:0] lane);
    return line[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ddr3_line_cache.sv
// Single 8-byte read line with tag, valid flag, lane read mux and write-through update.
module ddr3_line_cache
  import ddr3_byte_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inval,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              wt_en,
  input  logic [TAG_W-1:0]  wt_tag,
  input  logic [LANE_W-1:0] wt_lane,
  input  logic [7:0]        wt_byte,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic [LANE_W-1:0] lookup_lane,
  output logic              hit_c,
  output logic [7:0]        lookup_byte_c
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] line_q;

  // A fill in flight wins over a concurrent invalidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      line_q  <= fill_line;
    end else begin
      if (inval) valid_q <= 1'b0;
      if (wt_en && valid_q && (tag_q == wt_tag)) line_q[{wt_lane, 3'b000} +: 8] <= wt_byte;
    end
  end

  assign hit_c         = valid_q && (tag_q == lookup_tag);
  assign lookup_byte_c = lane_byte(line_q, lookup_lane);

endmodule

// File: rtl/ddr3_byte_bridge.sv
// Byte-wide request port to 64-bit Avalon-MM DDRAM bridge with a one-line read cache.
module ddr3_byte_bridge
  import ddr3_byte_bridge_pkg::*;
#(
  parameter logic [DDRAM_ADDR_W-1:0] BASE_WORD = 29'h0300000,
  parameter logic [7:0]              BURST     = 8'd1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQ_ADDR_W-1:0]      ddr3_addr,
  input  logic                       ddr3_rd,
  input  logic                       ddr3_wr,
  input  logic [7:0]                 ddr3_din,
  output logic [7:0]                 ddr3_dout,
  output logic                       ddr3_ready,
  input  logic                       ddr3_request,
  input  logic                       DDRAM_BUSY,
  output logic [7:0]                 DDRAM_BURSTCNT,
  output logic [DDRAM_ADDR_W-1:0]    DDRAM_ADDR,
  output logic                       DDRAM_RD,
  input  logic [LINE_W-1:0]          DDRAM_DOUT,
  input  logic                       DDRAM_DOUT_READY,
  output logic                       DDRAM_WE,
  output logic [LINE_W-1:0]          DDRAM_DIN,
  output logic [DDR3_LINE_BYTES-1:0] DDRAM_BE
);

  ddr3_bridge_state_t state_q, state_d;
  logic               ready_q, ready_d;
  logic [7:0]         dout_q, dout_d;
  logic               rd_q, rd_d;
  logic               we_q, we_d;
  ddram_req_t         avl_q, avl_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               req_q;
  logic               fill_en, wt_en, hit_c, drain_on_reset;
  logic [7:0]         hit_byte_c;
  logic [DDRAM_ADDR_W-1:0] word_addr;

  assign word_addr = DDRAM_ADDR_W'(BASE_WORD + {4'b0, ddr3_addr[REQ_ADDR_W-1:LANE_W]});

  // A read already accepted by the controller must have its data swallowed after reset.
  assign drain_on_reset = !DDRAM_DOUT_READY &&
                          ((state_q == RD_WAIT) || (state_q == DRAIN) ||
                           ((state_q == RD_ISSUE) && !DDRAM_BUSY));

  ddr3_line_cache u_cache (
    .clk          (clk),
    .reset        (reset),
    .inval        (req_q && !ddr3_request),
    .fill_en      (fill_en),
    .fill_tag     (tag_q),
    .fill_line    (DDRAM_DOUT),
    .wt_en        (wt_en),
    .wt_tag       (tag_q),
    .wt_lane      (lane_q),
    .wt_byte      (avl_q.din[7:0]),
    .lookup_tag   (ddr3_addr[REQ_ADDR_W-1:LANE_W]),
    .lookup_lane  (ddr3_addr[LANE_W-1:0]),
    .hit_c        (hit_c),
    .lookup_byte_c(hit_byte_c)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    we_d    = we_q;
    avl_d   = avl_q;
    tag_d   = tag_q;
    lane_d  = lane_q;
    fill_en = 1'b0;
    wt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && ddr3_wr) begin
          state_d   = WR_ISSUE;
          ready_d   = 1'b0;
          we_d      = 1'b1;
          avl_d.addr = word_addr;
          avl_d.din  = {DDR3_LINE_BYTES{ddr3_din}};
          avl_d.be   = DDR3_LINE_BYTES'(1) << ddr3_addr[LANE_W-1:0];
          tag_d     = ddr3_addr[REQ_ADDR_W-1:LANE_W];
          lane_d    = ddr3_addr[LANE_W-1:0];
        end else if (ready_q && ddr3_rd) begin
          if (hit_c) begin
            dout_d = hit_byte_c;
          end else begin
            state_d    = RD_ISSUE;
            ready_d    = 1'b0;
            rd_d       = 1'b1;
            avl_d.addr = word_addr;
            tag_d      = ddr3_addr[REQ_ADDR_W-1:LANE_W];
            lane_d     = ddr3_addr[LANE_W-1:0];
          end
        end
      end
      RD_ISSUE: begin
        if (!DDRAM_BUSY) begin
          rd_d    = 1'b0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          fill_en = 1'b1;
          dout_d  = lane_byte(DDRAM_DOUT, lane_q);
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      WR_ISSUE: begin
        if (!DDRAM_BUSY) begin
          wt_en   = 1'b1;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (DDRAM_DOUT_READY) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= drain_on_reset ? DRAIN : IDLE;
      ready_q <= !drain_on_reset;
      dout_q  <= 8'hFF;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      avl_q   <= '0;
      tag_q   <= '0;
      lane_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      avl_q   <= avl_d;
      tag_q   <= tag_d;
      lane_q  <= lane_d;
      req_q   <= ddr3_request;
    end
  end

  assign ddr3_dout      = dout_q;
  assign ddr3_ready     = ready_q;
  assign DDRAM_BURSTCNT = BURST;
  assign DDRAM_ADDR     = avl_q.addr;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_DIN      = avl_q.din;
  assign DDRAM_BE       = avl_q.be;

endmodule

// File: tb/tb_ddr3_byte_bridge.sv
// Directed self-checking bench for ddr3_byte_bridge: miss, hit, write-through, reset drain, invalidate.
module tb_ddr3_byte_bridge;

  localparam logic [28:0] BASE = 29'h0300000;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] ddr3_addr;
  logic        ddr3_rd, ddr3_wr;
  logic [7:0]  ddr3_din;
  logic [7:0]  ddr3_dout;
  logic        ddr3_ready;
  logic        ddr3_request;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;

  int n_checks = 0;
  int n_fail   = 0;

  ddr3_byte_bridge dut (
    .clk(clk), .reset(reset), .ddr3_addr(ddr3_addr), .ddr3_rd(ddr3_rd), .ddr3_wr(ddr3_wr),
    .ddr3_din(ddr3_din), .ddr3_dout(ddr3_dout), .ddr3_ready(ddr3_ready),
    .ddr3_request(ddr3_request), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_RD(DDRAM_RD), .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ddr3_ready); end
    n_checks++; if (ddr3_dout !== 8'hFF) begin n_fail++; $display("FAIL reset_dout: got %h want ff", ddr3_dout); end
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", DDRAM_RD); end
    n_checks++; if (DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", DDRAM_WE); end
    n_checks++; if (DDRAM_BE !== 8'h00) begin n_fail++; $display("FAIL reset_be: got %h want 00", DDRAM_BE); end
    n_checks++; if (DDRAM_BURSTCNT !== 8'd1) begin n_fail++; $display("FAIL burstcnt: got %h want 01", DDRAM_BURSTCNT); end
  endtask

  task automatic test_read_miss();
    int low;
    ddr3_addr = 28'h0000012; ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    n_checks++; if (DDRAM_RD !== 1'b1) begin n_fail++; $display("FAIL miss_rd: got %b want 1", DDRAM_RD); end
    n_checks++; if (DDRAM_ADDR !== BASE + 29'd2) begin n_fail++; $display("FAIL miss_addr: got %h want %h", DDRAM_ADDR, BASE + 29'd2); end
    low = (ddr3_ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ddr3_ready === 1'b0) low++;
    end
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL miss_rd_drop: got %b want 0", DDRAM_RD); end
    DDRAM_DOUT = 64'h8877665544332211; DDRAM_DOUT_READY = 1'b1; tick(); DDRAM_DOUT_READY = 1'b0;
    n_checks++; if (low !== 6) begin n_fail++; $display("FAIL miss_ready_low: got %0d cycles want 6", low); end
    n_checks++; if (ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL miss_ready: got %b want 1", ddr3_ready); end
    n_checks++; if (ddr3_dout !== 8'h33) begin n_fail++; $display("FAIL miss_dout: got %h want 33", ddr3_dout); end
  endtask

  task automatic test_read_hit();
    ddr3_addr = 28'h0000017; ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    n_checks++; if (ddr3_dout !== 8'h88) begin n_fail++; $display("FAIL hit_dout: got %h want 88", ddr3_dout); end
    n_checks++; if (ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL hit_ready: got %b want 1", ddr3_ready); end
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL hit_rd: got %b want 0", DDRAM_RD); end
  endtask

  task automatic test_write_busy();
    int we_cnt;
    ddr3_addr = 28'h0000015; ddr3_din = 8'hA5; ddr3_wr = 1'b1; DDRAM_BUSY = 1'b1;
    tick(); ddr3_wr = 1'b0;
    n_checks++; if (DDRAM_BE !== 8'h20) begin n_fail++; $display("FAIL wr_be: got %h want 20", DDRAM_BE); end
    n_checks++; if (DDRAM_DIN !== {8{8'hA5}}) begin n_fail++; $display("FAIL wr_din: got %h want a5a5a5a5a5a5a5a5", DDRAM_DIN); end
    n_checks++; if (DDRAM_ADDR !== BASE + 29'd2) begin n_fail++; $display("FAIL wr_addr: got %h want %h", DDRAM_ADDR, BASE + 29'd2); end
    n_checks++; if (ddr3_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_low: got %b want 0", ddr3_ready); end
    we_cnt = (DDRAM_WE === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (DDRAM_WE === 1'b1) we_cnt++;
    end
    DDRAM_BUSY = 1'b0; tick();
    n_checks++; if (we_cnt !== 4) begin n_fail++; $display("FAIL wr_we_len: got %0d cycles want 4", we_cnt); end
    n_checks++; if (DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL wr_we_drop: got %b want 0", DDRAM_WE); end
    n_checks++; if (ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", ddr3_ready); end
    ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    n_checks++; if (ddr3_dout !== 8'hA5) begin n_fail++; $display("FAIL wt_dout: got %h want a5", ddr3_dout); end
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL wt_rd: got %b want 0", DDRAM_RD); end
  endtask

  task automatic test_rd_wr_same();
    ddr3_addr = 28'h0000040; ddr3_din = 8'h3C; ddr3_rd = 1'b1; ddr3_wr = 1'b1;
    tick(); ddr3_rd = 1'b0; ddr3_wr = 1'b0;
    n_checks++; if (DDRAM_WE !== 1'b1) begin n_fail++; $display("FAIL both_we: got %b want 1", DDRAM_WE); end
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL both_rd: got %b want 0", DDRAM_RD); end
    n_checks++; if (DDRAM_BE !== 8'h01) begin n_fail++; $display("FAIL both_be: got %h want 01", DDRAM_BE); end
    n_checks++; if (DDRAM_ADDR !== BASE + 29'd8) begin n_fail++; $display("FAIL both_addr: got %h want %h", DDRAM_ADDR, BASE + 29'd8); end
    tick();
    n_checks++; if (DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL both_we_drop: got %b want 0", DDRAM_WE); end
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL both_rd_after: got %b want 0", DDRAM_RD); end
    n_checks++; if (ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL both_ready: got %b want 1", ddr3_ready); end
  endtask

  task automatic test_reset_in_rd_wait();
    ddr3_addr = 28'h0000080; ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (ddr3_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready0: got %b want 0", ddr3_ready); end
    n_checks++; if (ddr3_dout !== 8'hFF) begin n_fail++; $display("FAIL drain_dout0: got %h want ff", ddr3_dout); end
    tick(); tick();
    n_checks++; if (ddr3_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready2: got %b want 0", ddr3_ready); end
    DDRAM_DOUT = 64'hDEADBEEFCAFEF00D; DDRAM_DOUT_READY = 1'b1; tick(); DDRAM_DOUT_READY = 1'b0;
    n_checks++; if (ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b want 1", ddr3_ready); end
    n_checks++; if (ddr3_dout !== 8'hFF) begin n_fail++; $display("FAIL drain_discard: got %h want ff", ddr3_dout); end
    ddr3_addr = 28'h0000015; ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    n_checks++; if (DDRAM_RD !== 1'b1) begin n_fail++; $display("FAIL post_reset_miss: got %b want 1", DDRAM_RD); end
    tick();
    DDRAM_DOUT = 64'h0807060504030201; DDRAM_DOUT_READY = 1'b1; tick(); DDRAM_DOUT_READY = 1'b0;
    n_checks++; if (ddr3_dout !== 8'h06) begin n_fail++; $display("FAIL post_reset_dout: got %h want 06", ddr3_dout); end
  endtask

  task automatic test_request_invalidate();
    ddr3_addr = 28'h0000012; ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    n_checks++; if (ddr3_dout !== 8'h03 || DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL pre_inval_hit: got dout %h rd %b want 03/0", ddr3_dout, DDRAM_RD); end
    ddr3_request = 1'b0; tick();
    ddr3_rd = 1'b1; DDRAM_BUSY = 1'b1; tick();
    n_checks++; if (DDRAM_RD !== 1'b1) begin n_fail++; $display("FAIL inval_miss_rd: got %b want 1", DDRAM_RD); end
    n_checks++; if (ddr3_ready !== 1'b0) begin n_fail++; $display("FAIL inval_ready: got %b want 0", ddr3_ready); end
    tick(); ddr3_rd = 1'b0;
    n_checks++; if (DDRAM_RD !== 1'b1) begin n_fail++; $display("FAIL rd_hold_busy: got %b want 1", DDRAM_RD); end
    DDRAM_BUSY = 1'b0; tick();
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL rd_release: got %b want 0", DDRAM_RD); end
    ddr3_rd = 1'b1; tick(); ddr3_rd = 1'b0;
    n_checks++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL ignored_pulse_rd: got %b want 0", DDRAM_RD); end
    DDRAM_DOUT = 64'h1122334455667788; DDRAM_DOUT_READY = 1'b1; tick(); DDRAM_DOUT_READY = 1'b0;
    n_checks++; if (ddr3_dout !== 8'h66) begin n_fail++; $display("FAIL inval_fill_dout: got %h want 66", ddr3_dout); end
    tick();
    n_checks++; if (DDRAM_RD !== 1'b0 || ddr3_ready !== 1'b1) begin n_fail++; $display("FAIL no_extra_rd: got rd %b ready %b want 0/1", DDRAM_RD, ddr3_ready); end
    ddr3_request = 1'b1;
  endtask

  initial begin
    reset = 1'b1; ddr3_addr = '0; ddr3_rd = 1'b0; ddr3_wr = 1'b0; ddr3_din = '0;
    ddr3_request = 1'b1; DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_busy();
    test_rd_wr_same();
    test_reset_in_rd_wait();
    test_request_invalidate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
